// File: rtl/uart_tx_cfg_if.sv
// Character-level bus between a TX FIFO or bus wrapper and the configurable UART transmitter.
// The baud-rate enable travels with it so one bundle carries everything the transmitter consumes.
interface uart_tx_cfg_if #(
  parameter int DBIT_MAX = 8
);
  logic                s_tick;
  logic                tx_start;
  logic [DBIT_MAX-1:0] din;
  logic [1:0]          data_bits;
  logic [1:0]          parity_mode;
  logic                stop_bits;
  logic                tx_ready;
  logic                tx_done_tick;
  logic                tx;

  modport master (
    output s_tick, tx_start, din, data_bits, parity_mode, stop_bits,
    input  tx_ready, tx_done_tick, tx
  );

  modport slave (
    input  s_tick, tx_start, din, data_bits, parity_mode, stop_bits,
    output tx_ready, tx_done_tick, tx
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits.
// Frame settings are latched on accept, so the caller may change them while a frame is in flight.
module uart_tx_cfg #(
  parameter int DBIT_MAX   = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic         clk,
  input  logic         reset,
  uart_tx_cfg_if.slave bus
);
  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam int BW = (DBIT_MAX > 2) ? $clog2(DBIT_MAX) : 1;
  localparam logic [TW-1:0] TICK_BIT  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_STOP2 = TW'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DBIT_MAX-1:0] shift_q, shift_d;
  logic [1:0]          nbits_q, nbits_d;
  logic [1:0]          pmode_q, pmode_d;
  logic                stop_q, stop_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                done;

  logic [DBIT_MAX-1:0] shifted;
  logic                par_next;
  logic                par_en;
  logic [BW-1:0]       bit_last;
  logic [TW-1:0]       stop_end;

  always_comb begin
    shifted  = shift_q >> 1;
    par_next = par_q ^ shift_q[0];
    par_en   = (pmode_q == 2'b01) || (pmode_q == 2'b10);
    bit_last = BW'(nbits_q) + BW'(4);
    stop_end = stop_q ? TICK_STOP2 : TICK_BIT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      nbits_q <= '0;
      pmode_q <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      nbits_q <= nbits_d;
      pmode_q <= pmode_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is computed on each state transition so the line changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    nbits_d = nbits_q;
    pmode_d = pmode_q;
    stop_d  = stop_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          shift_d = bus.din;
          nbits_d = bus.data_bits;
          pmode_d = bus.parity_mode;
          stop_d  = bus.stop_bits;
          tick_d  = '0;
          bit_d   = '0;
          par_d   = 1'b0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (tick_q == TICK_BIT) begin
            tick_d  = '0;
            bit_d   = '0;
            tx_d    = shift_q[0];
            state_d = DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (tick_q == TICK_BIT) begin
            tick_d  = '0;
            shift_d = shifted;
            par_d   = par_next;
            if (bit_q == bit_last) begin
              if (par_en) begin
                tx_d    = (pmode_q == 2'b10) ? ~par_next : par_next;
                state_d = PARITY;
              end else begin
                tx_d    = 1'b1;
                state_d = STOP;
              end
            end else begin
              bit_d = bit_q + 1'b1;
              tx_d  = shifted[0];
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bus.s_tick) begin
          if (tick_q == TICK_BIT) begin
            tick_d  = '0;
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (tick_q == stop_end) begin
            tick_d  = '0;
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx           = tx_q;
  assign bus.tx_ready     = (state_q == IDLE);
  assign bus.tx_done_tick = done;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: directed frames feed a scoreboard of hand-computed line sequences,
// and a negedge monitor reassembles each frame from tx at every s_tick and checks it on tx_done_tick.
module tb_uart_tx_cfg;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  uart_tx_cfg_if #(.DBIT_MAX(8)) bus ();

  uart_tx_cfg #(.DBIT_MAX(8), .OVERSAMPLE(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One s_tick every 4 clocks, driven away from the sampling points.
  initial begin
    bus.s_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #2 bus.s_tick = 1'b1;
      @(posedge clk);
      #2 bus.s_tick = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  string exp_bits_q[$];
  int    exp_ticks_q[$];
  string exp_name_q[$];

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: one character per bit period, taken at the first tick of the bit.
  initial begin
    bit    in_frame = 0;
    bit    glitch = 0;
    bit    ready_hi = 0;
    logic  cur = 1'b1;
    int    ticks = 0;
    string obs = "";
    string eb;
    string en;
    int    et;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame = 0;
      end else begin
        if (in_frame) begin
          if (bus.tx_ready) ready_hi = 1;
          if (bus.s_tick) begin
            if ((ticks % 16) == 0) begin
              cur = bus.tx;
              if (bus.tx) obs = {obs, "1"};
              else        obs = {obs, "0"};
            end else if (bus.tx !== cur) begin
              glitch = 1;
            end
            ticks++;
          end
          if (bus.tx_done_tick) begin
            in_frame = 0;
            vectors++;
            if (exp_bits_q.size() == 0) begin
              miscompares++;
              $display("FAIL unexpected_frame: got bits %s, expected no frame", obs);
            end else begin
              eb = exp_bits_q.pop_front();
              et = exp_ticks_q.pop_front();
              en = exp_name_q.pop_front();
              if (obs != eb) begin
                miscompares++;
                $display("FAIL %s_bits: got %s, expected %s", en, obs, eb);
              end
              chk({en, "_done_ticks"}, ticks, et);
              chk({en, "_bit_stable"}, int'(glitch), 0);
              chk({en, "_ready_low"}, int'(ready_hi), 0);
            end
          end
        end else if (bus.tx_done_tick) begin
          chk("stray_done", 1, 0);
        end
        if (!in_frame && bus.tx_ready && bus.tx_start) begin
          in_frame = 1;
          glitch   = 0;
          ready_hi = 0;
          ticks    = 0;
          obs      = "";
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget, input string nm);
    int n = 0;
    while (bus.tx_ready !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (bus.tx_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got tx_ready=0 after %0d clocks, expected 1", nm, budget);
    end
  endtask

  task automatic set_cfg(input logic [7:0] d, input logic [1:0] db, input logic [1:0] pm,
                         input logic sb);
    bus.din         = d;
    bus.data_bits   = db;
    bus.parity_mode = pm;
    bus.stop_bits   = sb;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] db, input logic [1:0] pm,
                      input logic sb, input bit expect_it, input string eb, input int et,
                      input string nm);
    if (expect_it) begin
      exp_bits_q.push_back(eb);
      exp_ticks_q.push_back(et);
      exp_name_q.push_back(nm);
    end
    set_cfg(d, db, pm, sb);
    bus.tx_start = 1'b1;
    step();
    bus.tx_start = 1'b0;
  endtask

  initial begin
    bit idle_ok;
    reset        = 1'b1;
    bus.tx_start = 1'b0;
    set_cfg(8'h00, 2'b11, 2'b00, 1'b0);
    repeat (3) step();
    chk("reset_tx", int'(bus.tx), 1);
    chk("reset_ready", int'(bus.tx_ready), 1);
    chk("reset_done", int'(bus.tx_done_tick), 0);
    reset = 1'b0;
    step();

    // 8N1, 7E1 (bit 7 of din unused), 5O2
    send(8'hA5, 2'b11, 2'b00, 1'b0, 1, "0101001011", 160, "8N1_A5");
    wait_ready(2000, "8N1_A5");
    chk("idle_tx_after_8N1", int'(bus.tx), 1);
    send(8'h35, 2'b10, 2'b01, 1'b0, 1, "0101011001", 160, "7E1_35");
    wait_ready(2000, "7E1_35");
    send(8'h13, 2'b00, 2'b10, 1'b1, 1, "011001011", 144, "5O2_13");
    wait_ready(2000, "5O2_13");

    // Back-to-back with tx_start held, din and config changed while busy
    exp_bits_q.push_back("0101010101"); exp_ticks_q.push_back(160); exp_name_q.push_back("b2b_55");
    exp_bits_q.push_back("0010101011"); exp_ticks_q.push_back(160); exp_name_q.push_back("b2b_AA");
    set_cfg(8'h55, 2'b11, 2'b00, 1'b0);
    bus.tx_start = 1'b1;
    step();
    bus.din = 8'hAA;
    wait_ready(2000, "b2b_55");
    chk("b2b_gap_tx_high", int'(bus.tx), 1);
    step();
    chk("b2b_second_start_tx", int'(bus.tx), 0);
    chk("b2b_second_busy", int'(bus.tx_ready), 0);
    bus.tx_start = 1'b0;
    repeat (200) step();
    set_cfg(8'h00, 2'b00, 2'b10, 1'b1);
    wait_ready(2000, "b2b_AA");

    // Busy request dropped, not queued
    send(8'h00, 2'b11, 2'b00, 1'b0, 1, "0000000001", 160, "busy_00");
    repeat (150) step();
    bus.din      = 8'hFF;
    bus.tx_start = 1'b1;
    step();
    bus.tx_start = 1'b0;
    chk("busy_ready_low", int'(bus.tx_ready), 0);
    wait_ready(2000, "busy_00");
    idle_ok = 1;
    repeat (200) begin
      step();
      if (bus.tx !== 1'b1 || bus.tx_ready !== 1'b1) idle_ok = 0;
    end
    chk("busy_no_queued_frame", int'(idle_ok), 1);

    // Reset during PARITY of an 8E1 frame, then a clean 8N1 frame
    send(8'h0F, 2'b11, 2'b01, 1'b0, 0, "", 0, "aborted");
    repeat (600) step();
    chk("pre_reset_busy", int'(bus.tx_ready), 0);
    reset = 1'b1;
    step();
    chk("midreset_tx", int'(bus.tx), 1);
    chk("midreset_ready", int'(bus.tx_ready), 1);
    chk("midreset_done", int'(bus.tx_done_tick), 0);
    reset = 1'b0;
    step();
    send(8'h3C, 2'b11, 2'b00, 1'b0, 1, "0001111001", 160, "post_reset_3C");
    wait_ready(2000, "post_reset_3C");
    repeat (10) step();

    chk("scoreboard_drained", exp_bits_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
